window_streamer: RTL
====================

# window_streamer

Parametrised 3x3 sliding-window generator for the image pipeline. It fetches a raster-ordered frame from a synchronous-read image memory (1-cycle read latency, same as the image storage ROM) and keeps two line buffers plus a 3x3 shift window. It emits every fully-interior 3x3 neighbourhood to downstream filters over a valid/ready handshake with full backpressure. It replaces whole-frame register storage with O(2·IMG_W) buffering and works for any frame size and pixel width.

## Interface
- PIX_W, 8, pixel width in bits
- IMG_W, 100, frame width in pixels (≥3)
- IMG_H, 100, frame height in pixels (≥3)
- AW, $clog2(IMG_W*IMG_H), memory address width
- XW / YW, $clog2(IMG_W) / $clog2(IMG_H), coordinate widths

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse that begins a frame; ignored while busy
- busy  out  1  high from the cycle after start is accepted until frame_done
- mem_en  out  1  read strobe to image memory
- mem_addr  out  AW  read address, raster order y*IMG_W+x
- mem_dout  in  PIX_W  read data, valid the cycle after mem_en
- win_data  out  9*PIX_W  window, row-major, top-left in MS bits: {p(r,c),p(r,c+1),p(r,c+2),p(r+1,c)…p(r+2,c+2)}
- win_row / win_col  out  YW / XW  top-left coordinate (r,c) of win_data
- win_valid  out  1  window valid
- win_ready  in  1  downstream accepts; transfer when valid&ready
- frame_done  out  1  one-cycle pulse after last window transfers

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 moves to FETCH and clears the fetch counter n, the pixel x/y counters and the hold register.
- FETCH: mem_en=1 with mem_addr=n, then n++, only when all of these hold: n < IMG_W*IMG_H, not stalled (stall = win_valid & !win_ready), and hold register empty. After issuing n=IMG_W*IMG_H-1, go to DRAIN.
- Returned pixel (y,x): shifts into the line buffers and window columns.
  - If y≥2 and x≥2, it completes window (y-2,x-2).
  - If the output register is free, or is being transferred this cycle, the window is loaded and win_valid is set.
  - Otherwise the pixel is parked in the 1-entry hold register and consumed on the first non-stalled cycle.
  - Pixels with x<2 or y<2 update the buffers only.
- Pixel value 0 is ordinary data; no pixel is skipped.
- DRAIN: wait until no reads are in flight, the hold register is empty, and the final window has transferred, then go to DONE.
- DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- Window count is (IMG_W-2)*(IMG_H-2), emitted in raster order of (r,c). Row wrap needs no bubble: the line-buffer index wraps at IMG_W.
- win_data, win_row and win_col are held stable while win_valid & !win_ready.
- start during busy has no effect. start in the DONE cycle is ignored.
- Reset, asserted at any time including mid-frame:
  - busy, mem_en, win_valid and frame_done go to 0 immediately.
  - mem_addr, win_data, win_row and win_col go to 0.
  - State returns to IDLE.
  - Line-buffer contents are don't-care; they are fully overwritten before use.

## Timing
- start sampled high in cycle 0.
- With win_ready held 1: pixel n is issued in cycle 1+n, its data returns in cycle 2+n, and the corresponding window is valid in cycle 3+n.
- First window: cycle 2*IMG_W+5.
- Last window valid: cycle IMG_W*IMG_H+2.
- frame_done: cycle IMG_W*IMG_H+3.
- Throughput is one pixel per cycle with no bubbles at row ends.
- Under backpressure, no more than one pixel is in flight plus one held; no pixel is lost or duplicated.
- busy falls in the same cycle frame_done pulses.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately, busy=0, no mem_en.
- IMG_W=5, IMG_H=4, mem[a]=a, win_ready=1, start at cycle 0:
  - mem_addr 0..19 in cycles 1..20.
  - First window at cycle 15 = {0,1,2,5,6,7,10,11,12} at (0,0).
  - Six windows, last {7,8,9,12,13,14,17,18,19} at (1,2) in cycle 22.
  - frame_done in cycle 23.
- Same frame with random win_ready (~50%):
  - Identical six windows in identical order.
  - win_data stable throughout every stall.
  - mem_addr strictly increments by 1 with no gaps or repeats.
- start pulsed mid-frame → ignored, output unchanged. start after frame_done → new frame beginning at mem_addr 0, same results.
- rst at cycle 17 of the 5x4 frame → immediate idle; a subsequent start yields a clean full six-window frame with no stale data.
- Default 100x100, mem[a]=a mod 256, win_ready=1:
  - 9604 windows.
  - First window in cycle 205.
  - Last window at (97,97) in cycle 10002.
  - frame_done in cycle 10003.

Source files
------------

// File: rtl/window_streamer.sv
// 3x3 sliding-window generator over a raster frame in sync-read memory.
// Two line buffers, a 2-column shift window, 1-entry hold, valid/ready out.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   start           one-cycle frame start, ignored while busy
//   busy            frame in progress
//   mem_en/addr     read strobe and raster address to image memory
//   mem_dout        read data, valid the cycle after mem_en
//   win_data        3x3 window, row-major, top-left in MS bits
//   win_row/col     top-left coordinate of win_data
//   win_valid/ready output handshake
//   frame_done      one-cycle pulse after the last window transfers
module window_streamer #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int AW = $clog2(IMG_W*IMG_H),
  parameter int XW = $clog2(IMG_W),
  parameter int YW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [PIX_W-1:0] mem_dout,
  output logic [9*PIX_W-1:0] win_data,
  output logic [YW-1:0]    win_row,
  output logic [XW-1:0]    win_col,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             frame_done
);

  localparam int NPIX = IMG_W*IMG_H;
  localparam logic [AW:0] N_END = (AW+1)'(NPIX);
  localparam logic [AW:0] N_LAST = (AW+1)'(NPIX-1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W-1);

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, DONE
  } state_t;

  state_t state;

  // n is one bit wider so it can reach IMG_W*IMG_H
  logic [AW:0] n;
  logic rd_vld;
  logic hold_vld;
  logic [PIX_W-1:0] hold_pix;
  logic [XW-1:0] px;
  logic [YW-1:0] py;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  // Only two window columns are stored; the
  // third is the incoming column itself.
  logic [PIX_W-1:0] c1t, c1m, c1b;
  logic [PIX_W-1:0] c2t, c2m, c2b;

  logic stall, src_vld, completes;
  logic take, park, emit;
  logic issue, drained;
  logic [PIX_W-1:0] src_pix, top, mid;

  always_comb begin
    stall = win_valid & ~win_ready;
    src_vld = rd_vld | hold_vld;
    src_pix = hold_vld ? hold_pix : mem_dout;
    completes = (py >= YW'(2)) &
                (px >= XW'(2));
    // Border pixels never need the output
    // register, so they are never parked.
    take = src_vld &
           (~stall | ~completes);
    park = rd_vld & ~take;
    emit = take & completes;
    issue = (state == FETCH) &
            (n < N_END) &
            ~stall & ~hold_vld;
    drained = ~rd_vld & ~hold_vld &
              (~win_valid | win_ready);
    top = lb1[px];
    mid = lb0[px];
  end

  assign mem_en = issue;
  assign mem_addr = n[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      rd_vld <= 1'b0;
      hold_vld <= 1'b0;
      hold_pix <= '0;
      px <= '0;
      py <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      win_valid <= 1'b0;
      win_data <= '0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      rd_vld <= issue;
      frame_done <= 1'b0;

      if (issue)
        n <= n + (AW+1)'(1);

      if (park) begin
        hold_vld <= 1'b1;
        hold_pix <= mem_dout;
      end else if (hold_vld & take) begin
        hold_vld <= 1'b0;
      end

      if (take) begin
        if (px == X_LAST) begin
          px <= '0;
          py <= py + YW'(1);
        end else begin
          px <= px + XW'(1);
        end
      end

      if (emit) begin
        win_valid <= 1'b1;
        win_data <= {c1t, c2t, top,
                     c1m, c2m, mid,
                     c1b, c2b, src_pix};
        win_row <= py - YW'(2);
        win_col <= px - XW'(2);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy <= 1'b1;
            n <= '0;
            px <= '0;
            py <= '0;
            hold_vld <= 1'b0;
          end
        end
        FETCH: begin
          if (issue && n == N_LAST)
            state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Buffer contents need no reset: every
  // entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (take) begin
      lb1[px] <= lb0[px];
      lb0[px] <= src_pix;
      c1t <= c2t;
      c2t <= top;
      c1m <= c2m;
      c2m <= mid;
      c1b <= c2b;
      c2b <= src_pix;
    end
  end

endmodule
